multicycle_ex_ctrl: RTL and testbench

- EX-stage sequencer, directly downstream of the pipeline control decoder. It consumes the decoder's instruction-type vector and FP-ALU start flag after they pass through the ID/EX register.
- For M-extension ops it runs a fixed-latency counter. For FP-ALU ops it performs the start/ready handshake with the FP ALU.
- While a multicycle op is in flight it stalls IF/ID/EX and bubbles EX/MEM, then releases the instruction with a one-cycle result-valid pulse.

---
 rtl/multicycle_ex_ctrl.sv | 132 +++++++++++++
 tb/tb_multicycle_ex_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_ex_ctrl.sv
// EX-stage sequencer for multicycle ops: fixed-latency M-extension divide and FP-ALU handshake.
// state   | meaning
// IDLE    | waiting for a multicycle op in EX
// DIV_RUN | M-extension unit counting down its fixed latency
// FP_WAIT | waiting for FP ALU ready, bounded by FP_TIMEOUT
// DONE    | result valid, pipeline released this cycle
module multicycle_ex_ctrl #(
  parameter int DIV_CYCLES = 8,
  parameter int FP_TIMEOUT = 64
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iValidEX,
  input  logic [13:0] iInstrTypeEX,
  input  logic        iFPALUStartEX,
  input  logic        iFPALUReady,
  input  logic        iFlush,
  output logic        oStall,
  output logic        oBubbleMEM,
  output logic        oDivStart,
  output logic        oFPALUStart,
  output logic        oResultValid,
  output logic        oBusy,
  output logic        oTimeout
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DIV_RUN = 2'd1;
  localparam logic [1:0] S_FP_WAIT = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);
  localparam logic [9:0] FP_LAST  = 10'(FP_TIMEOUT - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] divcnt_q, divcnt_d;
  logic [9:0] fpcnt_q, fpcnt_d;
  logic       timeout_q, timeout_d;

  logic det_div, det_fp;
  logic stall, bubble, div_start, fp_start, res_valid;
  logic unused_type;

  assign unused_type = ^{iInstrTypeEX[13:8], iInstrTypeEX[6:0]};

  assign det_div = iValidEX & iInstrTypeEX[7] & ~iFlush;
  assign det_fp  = iValidEX & iFPALUStartEX & ~iInstrTypeEX[7] & ~iFlush;

  always_comb begin
    state_d   = state_q;
    divcnt_d  = divcnt_q;
    fpcnt_d   = fpcnt_q;
    timeout_d = timeout_q;
    stall     = 1'b0;
    bubble    = 1'b0;
    div_start = 1'b0;
    fp_start  = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (det_div) begin
          stall     = 1'b1;
          bubble    = 1'b1;
          div_start = 1'b1;
          divcnt_d  = DIV_LOAD;
          state_d   = S_DIV_RUN;
        end else if (det_fp) begin
          // ready seen in the start cycle belongs to an older op and is ignored
          stall    = 1'b1;
          bubble   = 1'b1;
          fp_start = 1'b1;
          fpcnt_d  = 10'd0;
          state_d  = S_FP_WAIT;
        end
      end
      S_DIV_RUN: begin
        bubble = 1'b1;
        if (iFlush) begin
          state_d = S_IDLE;
        end else begin
          stall = 1'b1;
          if (divcnt_q == 8'd0) state_d = S_DONE;
          else                  divcnt_d = divcnt_q - 8'd1;
        end
      end
      S_FP_WAIT: begin
        bubble = 1'b1;
        if (iFlush) begin
          state_d = S_IDLE;
        end else begin
          stall = 1'b1;
          if (iFPALUReady) begin
            state_d = S_DONE;
          end else if (fpcnt_q == FP_LAST) begin
            timeout_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            fpcnt_d = fpcnt_q + 10'd1;
          end
        end
      end
      default: begin
        res_valid = ~iFlush;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state_q   <= S_IDLE;
      divcnt_q  <= 8'd0;
      fpcnt_q   <= 10'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      divcnt_q  <= divcnt_d;
      fpcnt_q   <= fpcnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Outputs are forced low for the whole reset window, including mid-operation.
  assign oStall       = iRST & stall;
  assign oBubbleMEM   = iRST & bubble;
  assign oDivStart    = iRST & div_start;
  assign oFPALUStart  = iRST & fp_start;
  assign oResultValid = iRST & res_valid;
  assign oBusy        = iRST & (state_q != S_IDLE);
  assign oTimeout     = iRST & timeout_q;

endmodule

// File: tb/tb_multicycle_ex_ctrl.sv
// Scoreboard bench for multicycle_ex_ctrl: per-cycle expected output vectors checked by a monitor.
module tb_multicycle_ex_ctrl;

  logic        iCLK;
  logic        iRST;
  logic        iValidEX;
  logic [13:0] iInstrTypeEX;
  logic        iFPALUStartEX;
  logic        iFPALUReady;
  logic        iFlush;
  logic        oStall, oBubbleMEM, oDivStart, oFPALUStart, oResultValid, oBusy, oTimeout;

  multicycle_ex_ctrl #(.DIV_CYCLES(8), .FP_TIMEOUT(64)) dut (
    .iCLK(iCLK), .iRST(iRST), .iValidEX(iValidEX), .iInstrTypeEX(iInstrTypeEX),
    .iFPALUStartEX(iFPALUStartEX), .iFPALUReady(iFPALUReady), .iFlush(iFlush),
    .oStall(oStall), .oBubbleMEM(oBubbleMEM), .oDivStart(oDivStart),
    .oFPALUStart(oFPALUStart), .oResultValid(oResultValid), .oBusy(oBusy),
    .oTimeout(oTimeout)
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  typedef struct {
    string      name;
    logic [6:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int checks = 0;
  int errors = 0;
  logic to_exp = 1'b0;

  // {stall, bubble, divstart, fpstart, resvalid, busy}; timeout appended separately
  localparam logic [5:0] E_IDLE   = 6'b000000;
  localparam logic [5:0] E_DIVS   = 6'b111000;
  localparam logic [5:0] E_FPS    = 6'b110100;
  localparam logic [5:0] E_RUN    = 6'b110001;
  localparam logic [5:0] E_DONE   = 6'b000011;
  localparam logic [5:0] E_FLUSH  = 6'b010001;
  localparam logic [5:0] E_DONEFL = 6'b000001;

  localparam logic [13:0] T_NONE = 14'h0000;
  localparam logic [13:0] T_DIV  = 14'h0090;
  localparam logic [13:0] T_FP   = 14'h0400;
  localparam logic [13:0] T_BOTH = 14'h0490;

  task automatic step(input logic rst, input logic v, input logic [13:0] ty,
                      input logic fs, input logic rdy, input logic fl,
                      input logic [5:0] e, input string nm);
    sb_item_t it;
    iRST          = rst;
    iValidEX      = v;
    iInstrTypeEX  = ty;
    iFPALUStartEX = fs;
    iFPALUReady   = rdy;
    iFlush        = fl;
    it.name = nm;
    it.exp  = {e, rst & to_exp};
    sb_q.push_back(it);
    if (!rst) to_exp = 1'b0;
    @(posedge iCLK);
    #1;
  endtask

  task automatic idle(input string nm);
    step(1'b1, 1'b0, T_NONE, 1'b0, 1'b0, 1'b0, E_IDLE, nm);
  endtask

  // Monitor: the DUT presents its combinational outputs every cycle; sample mid-cycle.
  initial begin
    sb_item_t it;
    logic [6:0] act;
    forever begin
      @(negedge iCLK);
      if (sb_q.size() > 0) begin
        it  = sb_q.pop_front();
        act = {oStall, oBubbleMEM, oDivStart, oFPALUStart, oResultValid, oBusy, oTimeout};
        checks++;
        if (act !== it.exp) begin
          errors++;
          $display("FAIL %s: got %b expected %b (stall,bubble,div,fp,rv,busy,to) at %0t",
                   it.name, act, it.exp, $time);
        end
      end
    end
  end

  initial begin
    iRST = 1'b0; iValidEX = 1'b0; iInstrTypeEX = T_NONE;
    iFPALUStartEX = 1'b0; iFPALUReady = 1'b0; iFlush = 1'b0;
    @(posedge iCLK);
    #1;

    repeat (2) step(1'b0, 1'b1, T_DIV, 1'b0, 1'b0, 1'b0, E_IDLE, "reset_hold");
    idle("reset_release");

    step(1'b1, 1'b1, T_DIV, 1'b0, 1'b0, 1'b0, E_DIVS, "div_start");
    for (int c = 1; c <= 8; c++) step(1'b1, 1'b1, T_DIV, 1'b0, 1'b0, 1'b0, E_RUN, "div_run");
    step(1'b1, 1'b1, T_DIV, 1'b0, 1'b0, 1'b0, E_DONE, "div_done");
    idle("div_after");

    repeat (2) step(1'b1, 1'b0, T_DIV, 1'b0, 1'b0, 1'b0, E_IDLE, "invalid_div");
    step(1'b1, 1'b1, T_DIV, 1'b0, 1'b0, 1'b1, E_IDLE, "flush_idle");

    step(1'b1, 1'b1, T_FP, 1'b1, 1'b1, 1'b0, E_FPS, "fp_start_stale_ready");
    for (int c = 1; c <= 4; c++) step(1'b1, 1'b1, T_FP, 1'b1, 1'b0, 1'b0, E_RUN, "fp_wait");
    step(1'b1, 1'b1, T_FP, 1'b1, 1'b1, 1'b0, E_RUN, "fp_ready");
    step(1'b1, 1'b1, T_FP, 1'b1, 1'b0, 1'b0, E_DONE, "fp_done");
    idle("fp_after");

    step(1'b1, 1'b1, T_BOTH, 1'b1, 1'b0, 1'b0, E_DIVS, "prio_div_wins");
    step(1'b1, 1'b1, T_BOTH, 1'b1, 1'b0, 1'b1, E_FLUSH, "prio_flush");
    idle("prio_after");

    step(1'b1, 1'b1, T_DIV, 1'b0, 1'b0, 1'b0, E_DIVS, "dflush_start");
    for (int c = 1; c <= 2; c++) step(1'b1, 1'b1, T_DIV, 1'b0, 1'b0, 1'b0, E_RUN, "dflush_run");
    step(1'b1, 1'b1, T_DIV, 1'b0, 1'b0, 1'b1, E_FLUSH, "div_flush");
    idle("div_flush_idle");
    idle("div_flush_no_rv");

    step(1'b1, 1'b1, T_FP, 1'b1, 1'b0, 1'b0, E_FPS, "fflush_start");
    step(1'b1, 1'b1, T_FP, 1'b1, 1'b1, 1'b1, E_FLUSH, "fp_flush");
    step(1'b1, 1'b0, T_NONE, 1'b0, 1'b1, 1'b0, E_IDLE, "fp_late_ready");

    step(1'b1, 1'b1, T_FP, 1'b1, 1'b0, 1'b0, E_FPS, "dnfl_start");
    step(1'b1, 1'b1, T_FP, 1'b1, 1'b1, 1'b0, E_RUN, "dnfl_ready");
    step(1'b1, 1'b1, T_FP, 1'b1, 1'b0, 1'b1, E_DONEFL, "done_flush");
    idle("done_flush_after");

    step(1'b1, 1'b1, T_DIV, 1'b0, 1'b0, 1'b0, E_DIVS, "b2b_div_start");
    for (int c = 1; c <= 8; c++) step(1'b1, 1'b1, T_DIV, 1'b0, 1'b0, 1'b0, E_RUN, "b2b_div_run");
    step(1'b1, 1'b1, T_DIV, 1'b0, 1'b0, 1'b0, E_DONE, "b2b_div_done");
    step(1'b1, 1'b1, T_FP, 1'b1, 1'b0, 1'b0, E_FPS, "b2b_fp_start");
    step(1'b1, 1'b1, T_FP, 1'b1, 1'b0, 1'b0, E_RUN, "b2b_fp_wait");
    step(1'b1, 1'b1, T_FP, 1'b1, 1'b1, 1'b0, E_RUN, "b2b_fp_ready");
    step(1'b1, 1'b1, T_FP, 1'b1, 1'b0, 1'b0, E_DONE, "b2b_fp_done");
    idle("b2b_after");

    step(1'b1, 1'b1, T_FP, 1'b1, 1'b0, 1'b0, E_FPS, "to_start");
    for (int c = 1; c <= 64; c++) step(1'b1, 1'b1, T_FP, 1'b1, 1'b0, 1'b0, E_RUN, "to_wait");
    to_exp = 1'b1;
    step(1'b1, 1'b1, T_FP, 1'b1, 1'b0, 1'b0, E_DONE, "to_done");
    idle("to_sticky_idle");
    step(1'b1, 1'b1, T_FP, 1'b1, 1'b0, 1'b0, E_FPS, "to_sticky_start");
    step(1'b1, 1'b1, T_FP, 1'b1, 1'b1, 1'b0, E_RUN, "to_sticky_ready");
    step(1'b1, 1'b1, T_FP, 1'b1, 1'b0, 1'b0, E_DONE, "to_sticky_done");
    idle("to_sticky_after");

    step(1'b1, 1'b1, T_DIV, 1'b0, 1'b0, 1'b0, E_DIVS, "rmid_start");
    step(1'b1, 1'b1, T_DIV, 1'b0, 1'b0, 1'b0, E_RUN, "rmid_run");
    step(1'b0, 1'b1, T_DIV, 1'b0, 1'b0, 1'b0, E_IDLE, "rmid_reset");
    idle("rmid_idle");
    idle("rmid_to_cleared");

    @(negedge iCLK);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
